// File: rtl/uart_serial_top.sv
// rtl/uart_serial_top.sv - UART 8N1 echo top; define SERIAL_TOP_FIFO_EN for a 16-entry rx-to-tx FIFO instead of a one-byte holding register
module uart_serial_top #(
  parameter logic [15:0] WTIME = 16'h364
) (
  input  logic clk,
  input  logic nrst,
  input  logic uart_txd_in,
  output logic uart_rxd_out
);

  localparam logic [15:0] HALF_CNT = WTIME >> 1;
  localparam logic [15:0] LAST_CNT = WTIME - 16'd1;

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  // input synchronizer and start-edge qualification
  logic       rx_sync1, rx_sync2, rx_prev, rx_armed;
  logic [1:0] rx_fill;
  logic       rx_fall;

  // receiver state
  rx_state_t  rx_state, rx_state_d;
  logic [15:0] rx_cnt, rx_cnt_d;
  logic [2:0] rx_bits, rx_bits_d;
  logic [7:0] rx_shift, rx_shift_d;
  logic       rx_push, rx_push_d;

  // buffer view seen by the transmitter
  logic       buf_nonempty;
  logic [7:0] buf_head;

  // transmitter state
  tx_state_t  tx_state, tx_state_d;
  logic [15:0] tx_cnt, tx_cnt_d;
  logic [2:0] tx_bits, tx_bits_d;
  logic [7:0] tx_shift, tx_shift_d;
  logic       tx_line, tx_line_d;
  logic       tx_pop;

  // rx_fill marks when the synchronizer holds real pin values; rx_armed waits for a high line
  // so a frame already running at reset release cannot fake a start edge
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rx_sync1 <= 1'b1;
      rx_sync2 <= 1'b1;
      rx_prev  <= 1'b1;
      rx_fill  <= 2'b00;
      rx_armed <= 1'b0;
    end else begin
      rx_sync1 <= uart_txd_in;
      rx_sync2 <= rx_sync1;
      rx_prev  <= rx_sync2;
      rx_fill  <= {rx_fill[0], 1'b1};
      rx_armed <= rx_armed | (rx_fill[1] & rx_sync2);
    end
  end

  assign rx_fall = rx_armed & rx_prev & ~rx_sync2;

  // receiver registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= 16'd0;
      rx_bits  <= 3'd0;
      rx_shift <= 8'd0;
      rx_push  <= 1'b0;
    end else begin
      rx_state <= rx_state_d;
      rx_cnt   <= rx_cnt_d;
      rx_bits  <= rx_bits_d;
      rx_shift <= rx_shift_d;
      rx_push  <= rx_push_d;
    end
  end

  // receiver next state: half-bit start check, then one mid-bit sample per WTIME
  always_comb begin
    rx_state_d = rx_state;
    rx_cnt_d   = rx_cnt;
    rx_bits_d  = rx_bits;
    rx_shift_d = rx_shift;
    rx_push_d  = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (rx_fall) begin
          rx_state_d = RX_START;
          rx_cnt_d   = HALF_CNT;
        end
      end
      RX_START: begin
        if (rx_cnt != 16'd0) begin
          rx_cnt_d = rx_cnt - 16'd1;
        end else if (rx_sync2) begin
          rx_state_d = RX_IDLE;
        end else begin
          rx_state_d = RX_DATA;
          rx_cnt_d   = LAST_CNT;
          rx_bits_d  = 3'd0;
        end
      end
      RX_DATA: begin
        if (rx_cnt != 16'd0) begin
          rx_cnt_d = rx_cnt - 16'd1;
        end else begin
          rx_shift_d = {rx_sync2, rx_shift[7:1]};
          rx_cnt_d   = LAST_CNT;
          if (rx_bits == 3'd7) rx_state_d = RX_STOP;
          else rx_bits_d = rx_bits + 3'd1;
        end
      end
      RX_STOP: begin
        if (rx_cnt != 16'd0) begin
          rx_cnt_d = rx_cnt - 16'd1;
        end else if (rx_sync2) begin
          rx_push_d  = 1'b1;
          rx_state_d = RX_IDLE;
        end else begin
          rx_state_d = RX_WAIT;
        end
      end
      RX_WAIT: begin
        if (rx_sync2) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

`ifdef SERIAL_TOP_FIFO_EN
  logic [7:0] fifo_mem [0:15];
  logic [3:0] wr_ptr, rd_ptr;
  logic [4:0] fifo_cnt;
  logic       fifo_wr;

  assign fifo_wr      = rx_push && (fifo_cnt != 5'd16);
  assign buf_nonempty = (fifo_cnt != 5'd0);
  assign buf_head     = fifo_mem[rd_ptr];

  // storage array, written only on accepted pushes
  always_ff @(posedge clk) begin
    if (fifo_wr) fifo_mem[wr_ptr] <= rx_shift;
  end

  // pointers and occupancy; a push into a full FIFO is dropped
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr   <= 4'd0;
      rd_ptr   <= 4'd0;
      fifo_cnt <= 5'd0;
    end else begin
      if (fifo_wr) wr_ptr <= wr_ptr + 4'd1;
      if (tx_pop) rd_ptr <= rd_ptr + 4'd1;
      case ({fifo_wr, tx_pop})
        2'b10:   fifo_cnt <= fifo_cnt + 5'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 5'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end
`else
  logic [7:0] hold_data;
  logic       hold_valid;

  assign buf_nonempty = hold_valid;
  assign buf_head     = hold_data;

  // single holding register; a new byte always replaces the held one
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      hold_data  <= 8'd0;
      hold_valid <= 1'b0;
    end else if (rx_push) begin
      hold_data  <= rx_shift;
      hold_valid <= 1'b1;
    end else if (tx_pop) begin
      hold_valid <= 1'b0;
    end
  end
`endif

  // transmitter registers; the line is registered so the pin never glitches
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= 16'd0;
      tx_bits  <= 3'd0;
      tx_shift <= 8'd0;
      tx_line  <= 1'b1;
    end else begin
      tx_state <= tx_state_d;
      tx_cnt   <= tx_cnt_d;
      tx_bits  <= tx_bits_d;
      tx_shift <= tx_shift_d;
      tx_line  <= tx_line_d;
    end
  end

  // transmitter next state; the end of a stop bit may load the next byte directly
  always_comb begin
    tx_state_d = tx_state;
    tx_cnt_d   = tx_cnt;
    tx_bits_d  = tx_bits;
    tx_shift_d = tx_shift;
    tx_line_d  = tx_line;
    tx_pop     = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        tx_line_d = 1'b1;
        if (buf_nonempty) tx_pop = 1'b1;
      end
      TX_START: begin
        if (tx_cnt != 16'd0) begin
          tx_cnt_d = tx_cnt - 16'd1;
        end else begin
          tx_state_d = TX_DATA;
          tx_cnt_d   = LAST_CNT;
          tx_bits_d  = 3'd0;
          tx_line_d  = tx_shift[0];
        end
      end
      TX_DATA: begin
        if (tx_cnt != 16'd0) begin
          tx_cnt_d = tx_cnt - 16'd1;
        end else begin
          tx_cnt_d = LAST_CNT;
          if (tx_bits == 3'd7) begin
            tx_state_d = TX_STOP;
            tx_line_d  = 1'b1;
          end else begin
            tx_bits_d  = tx_bits + 3'd1;
            tx_shift_d = {1'b0, tx_shift[7:1]};
            tx_line_d  = tx_shift[1];
          end
        end
      end
      TX_STOP: begin
        if (tx_cnt != 16'd0) begin
          tx_cnt_d = tx_cnt - 16'd1;
        end else if (buf_nonempty) begin
          tx_pop = 1'b1;
        end else begin
          tx_state_d = TX_IDLE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
    if (tx_pop) begin
      tx_state_d = TX_START;
      tx_cnt_d   = LAST_CNT;
      tx_shift_d = buf_head;
      tx_line_d  = 1'b0;
    end
  end

  assign uart_rxd_out = tx_line;

endmodule

// File: tb/tb_uart_serial_top.sv
// tb/tb_uart_serial_top.sv - randomized self-checking bench for uart_serial_top
module tb_uart_serial_top;

  localparam int W      = 16;
  localparam int LAT_LO = (19 * W) / 2 + 3;
  localparam int LAT_HI = (19 * W) / 2 + 8;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic uart_txd_in = 1'b1;
  logic uart_rxd_out;

  int cyc = 0;
  int checks = 0;
  int fails = 0;
  int mon_aborts = 0;

  logic [7:0] exp_data[$];
  int         exp_edge[$];
  logic [7:0] mon_data[$];
  int         mon_start[$];
  bit         mon_ok[$];

  uart_serial_top #(.WTIME(16'd16)) dut (
    .clk(clk),
    .nrst(nrst),
    .uart_txd_in(uart_txd_in),
    .uart_rxd_out(uart_rxd_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // decodes echoed frames by sampling mid-bit on falling clock edges
  initial begin : monitor
    logic       prev;
    logic [9:0] b;
    int         t0;
    bit         aborted;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (!nrst) begin
        prev = 1'b1;
      end else if (prev && !uart_rxd_out) begin
        t0 = cyc;
        aborted = 1'b0;
        b = '0;
        for (int n = 0; n <= W / 2 + 9 * W; n++) begin
          if (n > 0) @(negedge clk);
          if (!nrst) aborted = 1'b1;
          if (n >= W / 2 && ((n - W / 2) % W) == 0) b[(n - W / 2) / W] = uart_rxd_out;
        end
        if (aborted) begin
          mon_aborts++;
        end else begin
          mon_data.push_back(b[8:1]);
          mon_start.push_back(t0);
          mon_ok.push_back(b[0] == 1'b0 && b[9] == 1'b1);
        end
        prev = uart_rxd_out;
      end else begin
        prev = uart_rxd_out;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic v);
    uart_txd_in = v;
    repeat (W) @(posedge clk);
    #1;
  endtask

  task automatic host_frame(input logic [7:0] d, input logic stop_v);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop_v);
    uart_txd_in = 1'b1;
  endtask

  task automatic send_good(input logic [7:0] d);
    exp_data.push_back(d);
    exp_edge.push_back(cyc);
    host_frame(d, 1'b1);
  endtask

  task automatic idle(input int n);
    uart_txd_in = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_frames(input int n, input int budget);
    int k;
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (mon_data.size() < n && k < budget);
  endtask

  task automatic verify(input string tag, input bit spacing);
    int n;
    int lat;
    n = exp_data.size();
    check({tag, "_count"}, mon_data.size(), n);
    for (int i = 0; i < n && i < mon_data.size(); i++) begin
      check({tag, "_data"}, mon_data[i], exp_data[i]);
      check({tag, "_framing"}, mon_ok[i], 1);
      lat = mon_start[i] - exp_edge[i];
      check({tag, "_latency_in_window"}, (lat >= LAT_LO && lat <= LAT_HI), 1);
      if (spacing && i > 0) check({tag, "_frame_period"}, mon_start[i] - mon_start[i-1], 10 * W);
    end
    exp_data.delete();
    exp_edge.delete();
    mon_data.delete();
    mon_start.delete();
    mon_ok.delete();
  endtask

  initial begin : stimulus
    int k;
    logic [7:0] d;

    nrst = 1'b0;
    uart_txd_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_line_high", uart_rxd_out, 1);
    nrst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("idle_line_high", uart_rxd_out, 1);

    send_good(8'h5A);
    wait_frames(1, 30 * W);
    verify("single_5a", 1'b0);
    idle(25 * W);
    check("single_5a_no_extra", mon_data.size(), 0);
    check("single_5a_line_high", uart_rxd_out, 1);

    host_frame(8'hFF, 1'b0);
    idle(2 * W);
    idle(25 * W);
    check("framing_err_no_echo", mon_data.size(), 0);
    send_good(8'h01);
    wait_frames(1, 30 * W);
    verify("after_framing_err", 1'b0);

    uart_txd_in = 1'b0;
    @(posedge clk);
    #1;
    idle(25 * W);
    check("glitch_no_echo", mon_data.size(), 0);

    host_frame(8'h3C, 1'b1);
    k = 0;
    while (uart_rxd_out !== 1'b0 && k < 12 * W) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("reset_test_echo_started", uart_rxd_out, 0);
    idle(3 * W);
    nrst = 1'b0;
    #1;
    check("reset_mid_echo_line_high", uart_rxd_out, 1);
    repeat (2) @(posedge clk);
    #1;
    check("reset_mid_echo_still_high", uart_rxd_out, 1);
    nrst = 1'b1;
    idle(25 * W);
    check("reset_no_resumed_frame", mon_data.size(), 0);
    check("reset_aborted_frames", mon_aborts, 1);
    check("reset_after_line_high", uart_rxd_out, 1);
    send_good(8'hC3);
    wait_frames(1, 30 * W);
    verify("after_reset", 1'b0);

    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom);
      send_good(d);
      idle($urandom_range(0, 2 * W));
    end
    wait_frames(6, 30 * W);
    verify("random_gaps", 1'b0);

    for (int i = 0; i < 4; i++) send_good(8'hAA);
    wait_frames(4, 30 * W);
    verify("stream_aa", 1'b1);

    idle(2 * W);
    for (int i = 0; i < 20; i++) begin
      d = 8'($urandom);
      send_good(d);
    end
    wait_frames(20, 30 * W);
    verify("burst_20", 1'b1);
    idle(25 * W);
    check("burst_no_extra", mon_data.size(), 0);
    check("final_line_high", uart_rxd_out, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
